// File: rtl/request_latch.sv
// request_latch: front end of the elevator controller.
// Synchronizes and debounces the raw car (internal) and hall (external) buttons
// for floors 1-9, latches each qualified press as a sticky pending request, and
// runs a door dwell at any requested floor the car reaches. When the dwell
// completes, the requests for that floor are cleared.
//
// Optional feature macro: REQ_CANCEL_EN
//   defined   : a press on an already-set internal request bit clears it (toggle)
//   undefined : repeat presses are ignored; bits clear only through service
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   asynchronous, active-high; clears all state
//   int_buttons[8:0]   in   raw car buttons, bit n = floor n+1, asynchronous
//   ext_buttons[8:0]   in   raw hall buttons, bit n = floor n+1, asynchronous
//   current_floor[3:0] in   1..9 = at that floor, 0 or >9 = between floors
//   internal_requests  out  latched pending car requests
//   external_requests  out  latched pending hall requests
//   door_open          out  high while dwelling at a requested floor
//   serviced           out  one-cycle pulse when a floor's requests are cleared
module request_latch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES    = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] int_buttons,
  input  logic [8:0] ext_buttons,
  input  logic [3:0] current_floor,
  output logic [8:0] internal_requests,
  output logic [8:0] external_requests,
  output logic       door_open,
  output logic       serviced
);

  localparam int unsigned NUM_FLOORS = 9;
  localparam int unsigned NUM_BTN    = 2 * NUM_FLOORS;
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_BTN-1:0]      sync1_q, sync1_d;
  logic [NUM_BTN-1:0]      sync2_q, sync2_d;
  logic [CNT_W-1:0]        deb_cnt_q [NUM_BTN];
  logic [CNT_W-1:0]        deb_cnt_d [NUM_BTN];
  logic [NUM_FLOORS-1:0]   int_req_q, int_req_d;
  logic [NUM_FLOORS-1:0]   ext_req_q, ext_req_d;
  logic [3:0]              floor_q, floor_d;
  logic [CNT_W-1:0]        dwell_q, dwell_d;
  logic                    door_open_q, door_open_d;
  logic                    serviced_q, serviced_d;

  logic [NUM_BTN-1:0]      press_c;
  logic                    floor_valid_c;
  logic [NUM_FLOORS-1:0]   floor_oh_c;
  logic [NUM_FLOORS-1:0]   clear_c;

  // Synchronizers and per-button debounce counters; press_c pulses on the
  // edge where a counter reaches DEBOUNCE_CYCLES, then the counter saturates.
  always_comb begin
    sync1_d = {ext_buttons, int_buttons};
    sync2_d = sync1_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      press_c[i]   = 1'b0;
      deb_cnt_d[i] = deb_cnt_q[i];
      if (!sync2_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] != DEB_MAX) begin
        deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        press_c[i]   = (deb_cnt_q[i] == DEB_LAST);
      end
    end
  end

  // Current floor decode: one-hot of the floor the car sits at, or zero.
  always_comb begin
    floor_valid_c = (current_floor >= 4'd1) && (current_floor <= 4'd9);
    floor_oh_c    = '0;
    if (floor_valid_c) begin
      floor_oh_c = NUM_FLOORS'(1) << (current_floor - 4'd1);
    end
  end

  // Service FSM plus request bookkeeping; a clear on the service edge wins
  // over a press for the same floor on that edge.
  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dwell_d     = dwell_q;
    door_open_d = 1'b0;
    serviced_d  = 1'b0;
    clear_c     = '0;

    case (state_q)
      IDLE: begin
        if (floor_valid_c && |((int_req_q | ext_req_q) & floor_oh_c)) begin
          state_d     = DWELL;
          floor_d     = current_floor;
          dwell_d     = DWELL_LOAD;
          door_open_d = 1'b1;
        end
      end
      DWELL: begin
        if (current_floor != floor_q) begin
          // Car left mid-dwell: abandon without clearing.
          state_d = IDLE;
        end else if (dwell_q == '0) begin
          state_d    = IDLE;
          serviced_d = 1'b1;
          clear_c    = NUM_FLOORS'(1) << (floor_q - 4'd1);
        end else begin
          dwell_d     = dwell_q - CNT_W'(1);
          door_open_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef REQ_CANCEL_EN
    int_req_d = int_req_q ^ press_c[NUM_FLOORS-1:0];
`else
    int_req_d = int_req_q | press_c[NUM_FLOORS-1:0];
`endif
    ext_req_d = ext_req_q | press_c[NUM_BTN-1:NUM_FLOORS];
    int_req_d = int_req_d & ~clear_c;
    ext_req_d = ext_req_d & ~clear_c;
  end

  // All state, including the FSM and its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_cnt_q[i] <= '0;
      end
      int_req_q   <= '0;
      ext_req_q   <= '0;
      floor_q     <= '0;
      dwell_q     <= '0;
      door_open_q <= 1'b0;
      serviced_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      int_req_q   <= int_req_d;
      ext_req_q   <= ext_req_d;
      floor_q     <= floor_d;
      dwell_q     <= dwell_d;
      door_open_q <= door_open_d;
      serviced_q  <= serviced_d;
    end
  end

  assign internal_requests = int_req_q;
  assign external_requests = ext_req_q;
  assign door_open         = door_open_q;
  assign serviced          = serviced_q;

endmodule

// File: tb/tb_request_latch.sv
// Bench for request_latch: directed scenarios followed by random button and
// floor activity, all checked cycle by cycle against a run-length based model.
module tb_request_latch;

  localparam int DEB = 4;
  localparam int DW  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] int_buttons;
  logic [8:0] ext_buttons;
  logic [3:0] current_floor;
  logic [8:0] internal_requests;
  logic [8:0] external_requests;
  logic       door_open;
  logic       serviced;

  int n_vec = 0;
  int n_err = 0;

  request_latch #(.DEBOUNCE_CYCLES(DEB), .DWELL_CYCLES(DW), .CNT_W(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .int_buttons       (int_buttons),
    .ext_buttons       (ext_buttons),
    .current_floor     (current_floor),
    .internal_requests (internal_requests),
    .external_requests (external_requests),
    .door_open         (door_open),
    .serviced          (serviced)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a press fires when the run of consecutive raw-high samples,
  // seen two cycles late through the synchronizer, first equals DEB.
  int         run_now [18];
  int         run_old [18];
  logic [8:0] m_int, m_ext;
  logic       m_dwell, m_serv;
  int         m_floor, m_elapsed;
  logic [17:0] raw, ev;
  int         flr;

  always begin
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 18; i++) begin
        run_now[i] = 0;
        run_old[i] = 0;
      end
      m_int = '0; m_ext = '0; m_dwell = 1'b0; m_serv = 1'b0;
      m_floor = 0; m_elapsed = 0;
    end else begin
      raw = {ext_buttons, int_buttons};
      for (int i = 0; i < 18; i++) begin
        ev[i] = (run_old[i] == DEB);
        run_old[i] = run_now[i];
        if (raw[i]) run_now[i] = (run_now[i] > DEB) ? DEB + 1 : run_now[i] + 1;
        else        run_now[i] = 0;
      end
      flr = int'(current_floor);
      m_serv = 1'b0;
      if (!m_dwell) begin
        if (flr >= 1 && flr <= 9 && (m_int[flr-1] || m_ext[flr-1])) begin
          m_dwell = 1'b1; m_floor = flr; m_elapsed = 1;
        end
      end else if (flr != m_floor) begin
        m_dwell = 1'b0;
      end else if (m_elapsed == DW) begin
        m_dwell = 1'b0;
        m_serv  = 1'b1;
      end else begin
        m_elapsed++;
      end
`ifdef REQ_CANCEL_EN
      m_int = m_int ^ ev[8:0];
`else
      m_int = m_int | ev[8:0];
`endif
      m_ext = m_ext | ev[17:9];
      if (m_serv) begin
        m_int[m_floor-1] = 1'b0;
        m_ext[m_floor-1] = 1'b0;
      end
    end
    #1;
    check_eq("int_req", {23'd0, internal_requests}, {23'd0, m_int});
    check_eq("ext_req", {23'd0, external_requests}, {23'd0, m_ext});
    check_eq("door",    {31'd0, door_open},         {31'd0, m_dwell});
    check_eq("serv",    {31'd0, serviced},          {31'd0, m_serv});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample_post(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int door_cnt, serv_cnt;

  initial begin
    reset = 1'b1; int_buttons = '0; ext_buttons = '0; current_floor = 4'd0;
    tick(3);
    check_eq("rst_int",  {23'd0, internal_requests}, 32'd0);
    check_eq("rst_door", {31'd0, door_open},         32'd0);
    reset = 1'b0;
    tick(2);

    // Car button for floor 5, car at floor 1: latched six cycles after the rise.
    current_floor = 4'd1;
    int_buttons[4] = 1'b1;
    sample_post(5);
    check_eq("t1_early", {23'd0, internal_requests}, 32'h000);
    sample_post(1);
    check_eq("t1_latch", {23'd0, internal_requests}, 32'h010);
    tick(4);
    int_buttons[4] = 1'b0;
    tick(4);
    check_eq("t1_hold", {23'd0, internal_requests}, 32'h010);

    // Short hall press is filtered out.
    current_floor = 4'd0;
    ext_buttons[2] = 1'b1;
    tick(3);
    ext_buttons[2] = 1'b0;
    tick(10);
    check_eq("t2_glitch", {23'd0, external_requests}, 32'h000);

    // Latch hall request for floor 3, then arrive and count the dwell.
    ext_buttons[2] = 1'b1;
    tick(6);
    ext_buttons[2] = 1'b0;
    tick(3);
    check_eq("t3_latch", {23'd0, external_requests}, 32'h004);
    current_floor = 4'd3;
    door_cnt = 0; serv_cnt = 0;
    for (int c = 0; c < 30 && serv_cnt == 0; c++) begin
      sample_post(1);
      if (door_open) door_cnt++;
      if (serviced)  serv_cnt++;
    end
    check_eq("t3_door_cycles", door_cnt, DW);
    check_eq("t3_serviced",    serv_cnt, 1);
    check_eq("t3_cleared", {23'd0, external_requests}, 32'h000);
    sample_post(1);
    check_eq("t3_pulse_len", {31'd0, serviced}, 32'd0);
    tick(1);
    current_floor = 4'd0;

    // Dwell at floor 7 aborted by moving to floor 8 after three cycles.
    int_buttons[6] = 1'b1;
    tick(6);
    int_buttons[6] = 1'b0;
    tick(3);
    current_floor = 4'd7;
    serv_cnt = 0;
    sample_post(1);
    check_eq("t4_door_on", {31'd0, door_open}, 32'd1);
    sample_post(2);
    tick(1);
    current_floor = 4'd8;
    for (int c = 0; c < 6; c++) begin
      sample_post(1);
      if (serviced) serv_cnt++;
    end
    check_eq("t4_door_off", {31'd0, door_open}, 32'd0);
    check_eq("t4_bit_kept", {31'd0, internal_requests[6]}, 32'd1);
    check_eq("t4_no_serv",  serv_cnt, 0);
    tick(1);
    current_floor = 4'd0;

    // Two separate presses of car button for floor 2.
    int_buttons[1] = 1'b1;
    tick(6);
    int_buttons[1] = 1'b0;
    tick(4);
    check_eq("t6_first", {31'd0, internal_requests[1]}, 32'd1);
    int_buttons[1] = 1'b1;
    tick(6);
    int_buttons[1] = 1'b0;
    tick(4);
`ifdef REQ_CANCEL_EN
    check_eq("t6_second", {31'd0, internal_requests[1]}, 32'd0);
`else
    check_eq("t6_second", {31'd0, internal_requests[1]}, 32'd1);
`endif

    // Load several requests, start a dwell at floor 5, reset mid-dwell.
    ext_buttons = 9'h023;
    int_buttons[2] = 1'b1;
    tick(6);
    ext_buttons = '0;
    int_buttons = '0;
    tick(3);
    check_eq("t5_many", {31'd0, ($countones(internal_requests) + $countones(external_requests)) >= 5}, 32'd1);
    current_floor = 4'd5;
    sample_post(3);
    check_eq("t5_in_dwell", {31'd0, door_open}, 32'd1);
    tick(1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_int", {23'd0, internal_requests}, 32'd0);
    check_eq("t5_ext", {23'd0, external_requests}, 32'd0);
    check_eq("t5_door", {31'd0, door_open}, 32'd0);
    check_eq("t5_serv", {31'd0, serviced}, 32'd0);
    tick(2);
    reset = 1'b0;
    current_floor = 4'd0;

    // Random activity; per-cycle model checks do the work here.
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0)
          int_buttons[$urandom_range(0, 8)] ^= 1'b1;
        else
          ext_buttons[$urandom_range(0, 8)] ^= 1'b1;
      end
      if ($urandom_range(0, 15) == 0) current_floor = 4'($urandom_range(0, 10));
      if (c == 2000) reset = 1'b1;
      if (c == 2002) reset = 1'b0;
    end
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
